// File: rtl/cga_pkg.sv
// Shared CGA definitions: VRAM address width and the ISA/VRAM arbiter state encoding.
package cga_pkg;

    localparam int VRAM_AW_DEFAULT = 14;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACC2 = 3'd2,
        ST_ACC3 = 3'd3,
        ST_HOLD = 3'd4
    } cga_state_e;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// ISA-side VRAM bus. The host holds isa_req (with isa_we/isa_addr/isa_wdata stable) as a level
// until it samples isa_ready=1; read data is valid on isa_rdata from that cycle and is held.
interface cga_vram_arbiter_if
    import cga_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEFAULT
) ();

    logic               isa_req;
    logic               isa_we;
    logic [VRAM_AW-1:0] isa_addr;
    logic [7:0]         isa_wdata;
    logic [7:0]         isa_rdata;
    logic               isa_ready;

    modport master (
        output isa_req, isa_we, isa_addr, isa_wdata,
        input  isa_rdata, isa_ready
    );

    modport slave (
        input  isa_req, isa_we, isa_addr, isa_wdata,
        output isa_rdata, isa_ready
    );

endinterface

// File: rtl/cga_sequencer.sv
// Free-running 32-phase CGA bus sequencer: display fetch windows and the two ISA access slots.
module cga_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    output logic [4:0] clkdiv,
    output logic       vram_read,
    output logic       vram_read_a0,
    output logic       isa_op_enable
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkdiv <= 5'd0;
        end else begin
            clkdiv <= clkdiv + 5'd1;
        end
    end

    // Display owns VRAM in 1..13 and 17..29; ISA slots open at 14 and 30 and run three cycles.
    always_comb begin
        vram_read     = ((clkdiv >= 5'd1)  && (clkdiv <= 5'd13)) ||
                        ((clkdiv >= 5'd17) && (clkdiv <= 5'd29));
        vram_read_a0  = clkdiv[0];
        isa_op_enable = (clkdiv == 5'd14) || (clkdiv == 5'd30);
    end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the CGA VRAM SRAM between the CRTC display fetch and three-cycle ISA accesses,
// flagging any access slot the display fetch intrudes on.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int VRAM_AW = VRAM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vram_read,
    input  logic               vram_read_a0,
    input  logic               isa_op_enable,
    input  logic [VRAM_AW-2:0] disp_addr,
    cga_vram_arbiter_if.slave  isa,
    output logic [VRAM_AW-1:0] ram_addr,
    input  logic [7:0]         ram_din,
    output logic [7:0]         ram_dout,
    output logic               ram_we_n,
    output logic               contention,
    output cga_state_e         state_dbg
);

    cga_state_e         state;
    logic               lat_we;
    logic [VRAM_AW-1:0] lat_addr;
    logic [7:0]         lat_data;
    logic [7:0]         rdata_q;
    logic               acc1;
    logic               in_access;

    // Access cycle 1 is the WAIT cycle in which the slot opens; an abort takes precedence.
    always_comb begin
        acc1      = (state == ST_WAIT) && isa.isa_req && isa_op_enable;
        in_access = acc1 || (state == ST_ACC2) || (state == ST_ACC3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            rdata_q    <= 8'h00;
            contention <= 1'b0;
        end else begin
            if (in_access && vram_read) begin
                contention <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (isa.isa_req) begin
                        lat_we   <= isa.isa_we;
                        lat_addr <= isa.isa_addr;
                        lat_data <= isa.isa_wdata;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!isa.isa_req) begin
                        state <= ST_IDLE;
                    end else if (isa_op_enable) begin
                        state <= ST_ACC2;
                    end
                end
                ST_ACC2: state <= ST_ACC3;
                ST_ACC3: begin
                    if (!lat_we) begin
                        rdata_q <= ram_din;
                    end
                    state <= isa.isa_req ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!isa.isa_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Display fetch always wins the SRAM; the ISA cycle still completes, flagged as contention.
    always_comb begin
        ram_addr = (in_access && !vram_read) ? lat_addr : {disp_addr, vram_read_a0};
        ram_dout = lat_data;
        ram_we_n = !(lat_we && (acc1 || (state == ST_ACC2)) && !vram_read);
    end

    assign isa.isa_rdata = rdata_q;
    assign isa.isa_ready = !(isa.isa_req && (state != ST_HOLD));
    assign state_dbg     = state;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter, paced by a free-running cga_sequencer.
module tb_cga_vram_arbiter;
    import cga_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        seq_vr, a0, op_en, force_vr, vram_read;
    logic [4:0]  clkdiv;
    logic [12:0] disp_addr;
    logic [13:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic        ram_we_n, contention;
    cga_state_e  state_dbg;

    assign vram_read = seq_vr | force_vr;

    cga_vram_arbiter_if #(.VRAM_AW(14)) isa_if ();

    cga_sequencer u_seq (
        .clk(clk), .reset_n(reset_n), .clkdiv(clkdiv),
        .vram_read(seq_vr), .vram_read_a0(a0), .isa_op_enable(op_en)
    );

    cga_vram_arbiter #(.VRAM_AW(14)) dut (
        .clk(clk), .reset_n(reset_n), .vram_read(vram_read), .vram_read_a0(a0),
        .isa_op_enable(op_en), .disp_addr(disp_addr), .isa(isa_if),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_we_n(ram_we_n), .contention(contention), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        int          start_cd;
        int          exp_we_low;
        int          exp_first_cd;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    // ---------------- driver tasks ----------------
    task automatic wait_cd(input int cd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 70 && !hit; i++) begin
            @(posedge clk); #1;
            if (int'(clkdiv) == cd) hit = 1'b1;
        end
        if (!hit) check("wait_cd_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_xact(input logic we, input logic [13:0] addr, input logic [7:0] wd,
                            input logic [7:0] din, input int start_cd, input int force_cd,
                            output int we_low, output int first_cd, output int hits,
                            output int ready_low, output int bus_bad,
                            output logic f_we_n, output logic [13:0] f_addr,
                            output logic timeout);
        logic done;
        we_low = 0; first_cd = -1; hits = 0; ready_low = 0; bus_bad = 0;
        f_we_n = 1'bx; f_addr = 'x; done = 1'b0;
        wait_cd(start_cd);
        isa_if.isa_req   = 1'b1;
        isa_if.isa_we    = we;
        isa_if.isa_addr  = addr;
        isa_if.isa_wdata = wd;
        ram_din          = din;
        force_vr         = (int'(clkdiv) == force_cd);
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (force_vr) begin
                f_we_n = ram_we_n;
                f_addr = ram_addr;
            end
            if (!ram_we_n) begin
                we_low++;
                if (ram_addr !== addr || ram_dout !== wd || vram_read) bus_bad++;
            end
            if (ram_addr == addr) begin
                hits++;
                if (first_cd < 0) first_cd = int'(clkdiv);
            end
            if (isa_if.isa_ready) done = 1'b1;
            else ready_low++;
            @(posedge clk); #1;
            force_vr = (int'(clkdiv) == force_cd);
        end
        timeout        = !done;
        isa_if.isa_req = 1'b0;
        force_vr       = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- test ----------------
    initial begin
        int we_low, first_cd, hits, ready_low, bus_bad;
        logic f_we_n, timeout;
        logic [13:0] f_addr;
        logic [7:0] last_rdata;

        // Request lands in IDLE one cycle before the slot opens at 14 or 30.
        vecs[0] = '{1'b1, 14'h0123, 8'h41, 8'h00, 13, 2, 14, 8'h00};
        vecs[1] = '{1'b0, 14'h0123, 8'h00, 8'h5A, 13, 0, 14, 8'h5A};
        vecs[2] = '{1'b1, 14'h3FFF, 8'hFF, 8'h11, 29, 2, 30, 8'h5A};
        vecs[3] = '{1'b0, 14'h0000, 8'h00, 8'hA5, 29, 0, 30, 8'hA5};
        vecs[4] = '{1'b0, 14'h2001, 8'h00, 8'h3C, 13, 0, 14, 8'h3C};
        vecs[5] = '{1'b1, 14'h1000, 8'h00, 8'h77, 13, 2, 14, 8'h3C};

        reset_n = 1'b0;
        isa_if.isa_req = 1'b0; isa_if.isa_we = 1'b0;
        isa_if.isa_addr = '0; isa_if.isa_wdata = '0;
        force_vr = 1'b0; disp_addr = 13'h0AAA; ram_din = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we_n", 32'(ram_we_n), 32'd1);
        check("rst_rdata", 32'(isa_if.isa_rdata), 32'h00);
        check("rst_contention", 32'(contention), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_ready", 32'(isa_if.isa_ready), 32'd1);
        check("rst_ram_addr", 32'(ram_addr), 32'h1554);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp_rdata);
            run_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din, vecs[i].start_cd, -1,
                     we_low, first_cd, hits, ready_low, bus_bad, f_we_n, f_addr, timeout);
            check($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
            check($sformatf("v%0d_we_low", i), 32'(we_low), 32'(vecs[i].exp_we_low));
            check($sformatf("v%0d_first_cd", i), 32'(first_cd), 32'(vecs[i].exp_first_cd));
            check($sformatf("v%0d_acc_cycles", i), 32'(hits), 32'd3);
            check($sformatf("v%0d_ready_low", i), 32'(ready_low), 32'd4);
            check($sformatf("v%0d_bus", i), 32'(bus_bad), 32'd0);
            check($sformatf("v%0d_rdata", i), 32'(isa_if.isa_rdata), 32'(exp_q.pop_front()));
            check($sformatf("v%0d_contention", i), 32'(contention), 32'd0);
        end
        last_rdata = isa_if.isa_rdata;

        // Display fetch forced into ACC2 (clkdiv 15) of a write.
        run_xact(1'b1, 14'h0321, 8'hC3, 8'h00, 13, 15,
                 we_low, first_cd, hits, ready_low, bus_bad, f_we_n, f_addr, timeout);
        check("cont_timeout", 32'(timeout), 32'd0);
        check("cont_we_n_acc2", 32'(f_we_n), 32'd1);
        check("cont_addr_acc2", 32'(f_addr), 32'h1555);
        check("cont_we_low", 32'(we_low), 32'd1);
        check("cont_acc_cycles", 32'(hits), 32'd2);
        check("cont_ready_low", 32'(ready_low), 32'd4);
        check("cont_bus", 32'(bus_bad), 32'd0);
        check("cont_flag", 32'(contention), 32'd1);
        check("cont_rdata", 32'(isa_if.isa_rdata), 32'(last_rdata));
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("cont_sticky", 32'(contention), 32'd1);

        // Abort: request dropped while WAITing for the slot at 30.
        wait_cd(15);
        isa_if.isa_req = 1'b1; isa_if.isa_we = 1'b1;
        isa_if.isa_addr = 14'h0456; isa_if.isa_wdata = 8'h99;
        we_low = 0; hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!ram_we_n) we_low++;
            if (ram_addr == 14'h0456) hits++;
            if (c == 2) check("abort_in_wait", 32'(state_dbg), 32'(ST_WAIT));
            @(posedge clk); #1;
            if (c == 2) isa_if.isa_req = 1'b0;
        end
        @(negedge clk);
        check("abort_we_low", 32'(we_low), 32'd0);
        check("abort_acc_cycles", 32'(hits), 32'd0);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_ready", 32'(isa_if.isa_ready), 32'd1);

        // Reset pulsed during ACC2 of a write.
        wait_cd(13);
        isa_if.isa_req = 1'b1; isa_if.isa_we = 1'b1;
        isa_if.isa_addr = 14'h0777; isa_if.isa_wdata = 8'h5E;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_state_pre", 32'(state_dbg), 32'(ST_ACC2));
        check("rstmid_we_n_pre", 32'(ram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_we_n", 32'(ram_we_n), 32'd1);
        check("rstmid_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rstmid_rdata", 32'(isa_if.isa_rdata), 32'h00);
        check("rstmid_contention", 32'(contention), 32'd0);
        @(posedge clk); #1;
        isa_if.isa_req = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_we_n", 32'(ram_we_n), 32'd1);
        check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
